// File: rtl/mem_access_unit_if.sv
// Request and data-memory bus bundle for mem_access_unit.
// The slave modport is the unit; master is the requester/memory environment.
interface mem_access_unit_if;
    logic        start;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic        busy;
    logic        done;
    logic [31:0] rdata_out;
    logic        misaligned;

    modport master (
        output start, mem_read, mem_write, funct3, addr, wdata, dmem_resp, dmem_rdata,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        input  busy, done, rdata_out, misaligned
    );

    modport slave (
        input  start, mem_read, mem_write, funct3, addr, wdata, dmem_resp, dmem_rdata,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
        output busy, done, rdata_out, misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: captures one request, drives a word-aligned memory access, extends loads.
// Define MEM_MISALIGN_CHECK_EN to fault misaligned halfword/word accesses instead of issuing them.
module mem_access_unit (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic        rd_q, wr_q, fault_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        capture, fault_d;
    logic [1:0]  off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign capture = (state_q == StIdle) && bus.start;
    assign off     = addr_q[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    always_comb begin
        fault_d = 1'b0;
        if (bus.mem_read || bus.mem_write) begin
            if (bus.funct3[1:0] == 2'b01 && bus.addr[0]) begin
                fault_d = 1'b1;
            end else if (bus.funct3 == 3'b010 && bus.addr[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end
    end
`else
    assign fault_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            fault_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                rd_q     <= bus.mem_read;
                // A request with both flags set is treated as a load.
                wr_q     <= bus.mem_write && !bus.mem_read;
                fault_q  <= fault_d;
                funct3_q <= bus.funct3;
                addr_q   <= bus.addr;
                wdata_q  <= bus.wdata;
            end
            if (state_q == StAccess && bus.dmem_resp) begin
                rdata_q <= bus.dmem_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (!fault_d && (bus.mem_read || bus.mem_write)) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StAccess: begin
                if (bus.dmem_resp) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Memory-side strobes, lanes and address: held for all of ACCESS, zero elsewhere.
    always_comb begin
        bus.dmem_read    = 1'b0;
        bus.dmem_write   = 1'b0;
        bus.dmem_address = 32'h0;
        bus.dmem_wdata   = 32'h0;
        bus.dmem_mbe     = 4'b0000;
        if (state_q == StAccess) begin
            bus.dmem_address = {addr_q[31:2], 2'b00};
            if (rd_q) begin
                bus.dmem_read = 1'b1;
                bus.dmem_mbe  = 4'b1111;
            end else if (wr_q) begin
                bus.dmem_write = 1'b1;
                case (funct3_q)
                    3'b000: begin
                        bus.dmem_mbe   = 4'b0001 << off;
                        bus.dmem_wdata = wdata_q << {off, 3'b000};
                    end
                    3'b001: begin
                        bus.dmem_mbe   = addr_q[1] ? 4'b1100 : 4'b0011;
                        bus.dmem_wdata = addr_q[1] ? (wdata_q << 16) : wdata_q;
                    end
                    3'b010: begin
                        bus.dmem_mbe   = 4'b1111;
                        bus.dmem_wdata = wdata_q;
                    end
                    default: begin
                        bus.dmem_mbe   = 4'b0000;
                        bus.dmem_wdata = 32'h0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        sel_byte = 8'h0;
        unique case (off)
            2'b00: sel_byte = rdata_q[7:0];
            2'b01: sel_byte = rdata_q[15:8];
            2'b10: sel_byte = rdata_q[23:16];
            2'b11: sel_byte = rdata_q[31:24];
            default: sel_byte = 8'h0;
        endcase
    end

    assign sel_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    always_comb begin
        bus.rdata_out = 32'h0;
        if (state_q == StDone && rd_q && !fault_q) begin
            case (funct3_q)
                3'b000:  bus.rdata_out = {{24{sel_byte[7]}}, sel_byte};
                3'b100:  bus.rdata_out = {24'h0, sel_byte};
                3'b001:  bus.rdata_out = {{16{sel_half[15]}}, sel_half};
                3'b101:  bus.rdata_out = {16'h0, sel_half};
                3'b010:  bus.rdata_out = rdata_q;
                default: bus.rdata_out = 32'h0;
            endcase
        end
    end

    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = (state_q == StDone);
    assign bus.misaligned = (state_q == StDone) && fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
// Honours MEM_MISALIGN_CHECK_EN to pick the expected misalignment behaviour.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start      = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".rd"},    {31'h0, bus.dmem_read}, 32'h0);
        check({tag, ".wr"},    {31'h0, bus.dmem_write}, 32'h0);
        check({tag, ".adr"},   bus.dmem_address, 32'h0);
        check({tag, ".wdat"},  bus.dmem_wdata, 32'h0);
        check({tag, ".mbe"},   {28'h0, bus.dmem_mbe}, 32'h0);
    endtask

    task automatic check_strobes(input string tag, input logic erd, input logic ewr,
                                 input logic [31:0] eadr, input logic [31:0] ewd,
                                 input logic [3:0] embe);
        check({tag, ".rd"},   {31'h0, bus.dmem_read}, {31'h0, erd});
        check({tag, ".wr"},   {31'h0, bus.dmem_write}, {31'h0, ewr});
        check({tag, ".adr"},  bus.dmem_address, eadr);
        check({tag, ".wdat"}, bus.dmem_wdata, ewd);
        check({tag, ".mbe"},  {28'h0, bus.dmem_mbe}, {28'h0, embe});
        check({tag, ".busy"}, {31'h0, bus.busy}, 32'h1);
        check({tag, ".done"}, {31'h0, bus.done}, 32'h0);
    endtask

    // One request with dmem_resp in the first ACCESS cycle.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] mem_word, input logic erd, input logic ewr,
                           input logic [31:0] eadr, input logic [31:0] ewd,
                           input logic [3:0] embe, input logic [31:0] erdata);
        bus.start     = 1'b1;
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        step();
        clear_inputs();
        check_strobes({tag, ".acc"}, erd, ewr, eadr, ewd, embe);
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = mem_word;
        step();
        clear_inputs();
        check({tag, ".done"},  {31'h0, bus.done}, 32'h1);
        check({tag, ".rdata"}, bus.rdata_out, erdata);
        check({tag, ".mis"},   {31'h0, bus.misaligned}, 32'h0);
        check_quiet({tag, ".dq"});
        step();
        check({tag, ".done0"}, {31'h0, bus.done}, 32'h0);
        check({tag, ".busy0"}, {31'h0, bus.busy}, 32'h0);
        check({tag, ".rd0"},   bus.rdata_out, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        check("rst.busy", {31'h0, bus.busy}, 32'h0);
        check("rst.done", {31'h0, bus.done}, 32'h0);
        check("rst.rdata", bus.rdata_out, 32'h0);
        check("rst.mis", {31'h0, bus.misaligned}, 32'h0);
        check_quiet("rst");

        // Loads
        run_req("lb",  1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF_FF00,
                1, 0, 32'h1000, 32'h0, 4'b1111, 32'hFFFF_FF80);
        run_req("lbu", 1, 0, 3'b100, 32'h1001, 32'h0, 32'h80FF_FF00,
                1, 0, 32'h1000, 32'h0, 4'b1111, 32'h0000_00FF);
        run_req("lh",  1, 0, 3'b001, 32'h0002, 32'h0, 32'h8001_7FFF,
                1, 0, 32'h0000, 32'h0, 4'b1111, 32'hFFFF_8001);
        run_req("lhlo", 1, 0, 3'b001, 32'h0000, 32'h0, 32'h8001_7FFF,
                1, 0, 32'h0000, 32'h0, 4'b1111, 32'h0000_7FFF);
        run_req("lw",  1, 0, 3'b010, 32'h0010, 32'h0, 32'hCAFE_F00D,
                1, 0, 32'h0010, 32'h0, 4'b1111, 32'hCAFE_F00D);
        run_req("lund", 1, 0, 3'b110, 32'h0010, 32'h0, 32'hCAFE_F00D,
                1, 0, 32'h0010, 32'h0, 4'b1111, 32'h0);

        // Stores
        run_req("sh",  0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h1111_1111,
                0, 1, 32'h2000, 32'hBEEF_0000, 4'b1100, 32'h0);
        run_req("sb",  0, 1, 3'b000, 32'h5001, 32'h0000_00A5, 32'h0,
                0, 1, 32'h5000, 32'h0000_A500, 4'b0010, 32'h0);
        run_req("sw",  0, 1, 3'b010, 32'h6000, 32'h1234_5678, 32'h0,
                0, 1, 32'h6000, 32'h1234_5678, 4'b1111, 32'h0);

        // Both flags: load only
        run_req("rw",  1, 1, 3'b010, 32'h7000, 32'hFFFF_FFFF, 32'h0BAD_CAFE,
                1, 0, 32'h7000, 32'h0, 4'b1111, 32'h0BAD_CAFE);

        // Stall: lhu at 0, resp after 5 waiting cycles, start pulsed mid-wait
        bus.start    = 1'b1;
        bus.mem_read = 1'b1;
        bus.funct3   = 3'b101;
        bus.addr     = 32'h0;
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            check_strobes($sformatf("stall%0d", i), 1, 0, 32'h0, 32'h0, 4'b1111);
            if (i == 2) begin
                bus.start     = 1'b1;
                bus.mem_write = 1'b1;
                bus.funct3    = 3'b010;
                bus.addr      = 32'h9000;
                bus.wdata     = 32'h5555_5555;
            end
            step();
            clear_inputs();
        end
        check_strobes("stall5", 1, 0, 32'h0, 32'h0, 4'b1111);
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1234_ABCD;
        step();
        clear_inputs();
        check("stall.done", {31'h0, bus.done}, 32'h1);
        check("stall.rdata", bus.rdata_out, 32'h0000_ABCD);
        // Start in DONE is dropped too
        bus.start    = 1'b1;
        bus.mem_read = 1'b1;
        step();
        clear_inputs();
        check("stall.done0", {31'h0, bus.done}, 32'h0);
        check("stall.busy0", {31'h0, bus.busy}, 32'h0);
        step();
        check("stall.busy1", {31'h0, bus.busy}, 32'h0);
        check_quiet("stall.q");

        // dmem_resp outside ACCESS is ignored
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hFFFF_FFFF;
        step();
        clear_inputs();
        check("idle_resp.done", {31'h0, bus.done}, 32'h0);
        check("idle_resp.busy", {31'h0, bus.busy}, 32'h0);

        // Reset during ACCESS
        bus.start    = 1'b1;
        bus.mem_read = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h0040;
        step();
        clear_inputs();
        check_strobes("rstacc", 1, 0, 32'h0040, 32'h0, 4'b1111);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rstacc.busy", {31'h0, bus.busy}, 32'h0);
        check_quiet("rstacc.q");
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hAAAA_AAAA;
        step();
        clear_inputs();
        check("rstacc.done", {31'h0, bus.done}, 32'h0);
        check("rstacc.rdata", bus.rdata_out, 32'h0);
        step();
        check("rstacc.done2", {31'h0, bus.done}, 32'h0);
        check("rstacc.busy2", {31'h0, bus.busy}, 32'h0);

        // Misaligned word load
`ifdef MEM_MISALIGN_CHECK_EN
        bus.start    = 1'b1;
        bus.mem_read = 1'b1;
        bus.funct3   = 3'b010;
        bus.addr     = 32'h3001;
        step();
        clear_inputs();
        check("mis.done", {31'h0, bus.done}, 32'h1);
        check("mis.flag", {31'h0, bus.misaligned}, 32'h1);
        check("mis.rdata", bus.rdata_out, 32'h0);
        check_quiet("mis.q");
        step();
        check("mis.flag0", {31'h0, bus.misaligned}, 32'h0);
        check("mis.busy0", {31'h0, bus.busy}, 32'h0);
`else
        run_req("mis", 1, 0, 3'b010, 32'h3001, 32'h0, 32'hDEAD_BEEF,
                1, 0, 32'h3000, 32'h0, 4'b1111, 32'hDEAD_BEEF);
`endif

        // No-access request
        bus.start = 1'b1;
        bus.addr  = 32'h4444;
        step();
        clear_inputs();
        check("noacc.done", {31'h0, bus.done}, 32'h1);
        check("noacc.busy", {31'h0, bus.busy}, 32'h1);
        check("noacc.rdata", bus.rdata_out, 32'h0);
        check("noacc.mis", {31'h0, bus.misaligned}, 32'h0);
        check_quiet("noacc.q");
        step();
        check("noacc.done0", {31'h0, bus.done}, 32'h0);
        check("noacc.busy0", {31'h0, bus.busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
